// File: rtl/granule_splitter.sv
// granule_splitter: buffers one two-channel frame of 2*GR_LEN samples, then
// replays granule 0 and granule 1 side by side for GR_LEN beats.
// Optional build macro GRANULE_SPLITTER_ERR_EN adds a sticky err_out flag.
module granule_splitter #(
  parameter int WIDTH  = 32,
  parameter int GR_LEN = 576
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_frame_start,
  input  logic signed [WIDTH-1:0] ch1_in,
  input  logic signed [WIDTH-1:0] ch2_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] gr1_ch1_out,
  output logic signed [WIDTH-1:0] gr1_ch2_out,
  output logic signed [WIDTH-1:0] gr2_ch1_out,
  output logic signed [WIDTH-1:0] gr2_ch2_out,
  output logic                    valid_out,
`ifdef GRANULE_SPLITTER_ERR_EN
  output logic                    err_out,
`endif
  output logic                    done_out
);

  localparam int DEPTH = 2 * GR_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_RD_C = CW'(GR_LEN - 1);
  localparam logic [AW-1:0] GR_LEN_A  = AW'(GR_LEN);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          issue_p1_q, issue_p1_d, issue_p2_q, issue_p2_d;
  logic          done_p1_q, done_p1_d, done_p2_q, done_p2_d;
  logic          wr_en, rd_en, last_issue;
  logic [AW-1:0] addr_a, addr_b;

  logic signed [WIDTH-1:0] mem_ch1 [DEPTH];
  logic signed [WIDTH-1:0] mem_ch2 [DEPTH];
  logic signed [WIDTH-1:0] dout_ch1_a_q, dout_ch1_b_q, dout_ch2_a_q, dout_ch2_b_q;
  logic signed [WIDTH-1:0] gr1_ch1_q, gr1_ch1_d, gr1_ch2_q, gr1_ch2_d;
  logic signed [WIDTH-1:0] gr2_ch1_q, gr2_ch1_d, gr2_ch2_q, gr2_ch2_d;

  // Frame sequencing: fill counter, drain counter, and the read-issue pipeline.
  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    in_ready   = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    last_issue = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = (wr_cnt_q < DEPTH_C);
        if (in_valid && in_ready) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (wr_cnt_q == DEPTH_C) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_en = 1'b1;
        if (rd_cnt_q == LAST_RD_C) begin
          last_issue = 1'b1;
          state_d    = DONE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FILL;
      end
    endcase
    if (new_frame_start) begin
      state_d    = FILL;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      last_issue = 1'b0;
    end
    issue_p1_d = rd_en;
    done_p1_d  = last_issue;
    issue_p2_d = new_frame_start ? 1'b0 : issue_p1_q;
    done_p2_d  = new_frame_start ? 1'b0 : done_p1_q;
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      issue_p1_q <= 1'b0;
      issue_p2_q <= 1'b0;
      done_p1_q  <= 1'b0;
      done_p2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      issue_p1_q <= issue_p1_d;
      issue_p2_q <= issue_p2_d;
      done_p1_q  <= done_p1_d;
      done_p2_q  <= done_p2_d;
    end
  end

  // Port A shares write (fill) and granule-0 read (drain); port B reads granule 1.
  always_comb begin
    addr_a = (state_q == FILL) ? wr_cnt_q[AW-1:0] : rd_cnt_q[AW-1:0];
    addr_b = rd_cnt_q[AW-1:0] + GR_LEN_A;
  end

  // Dual-port frame memories with the first (array) read register stage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ch1[addr_a] <= ch1_in;
      mem_ch2[addr_a] <= ch2_in;
    end
    if (rd_en) begin
      dout_ch1_a_q <= mem_ch1[addr_a];
      dout_ch1_b_q <= mem_ch1[addr_b];
      dout_ch2_a_q <= mem_ch2[addr_a];
      dout_ch2_b_q <= mem_ch2[addr_b];
    end
  end

  // Second read stage loads only behind a real read, so idle phases hold the last beat.
  always_comb begin
    gr1_ch1_d = gr1_ch1_q;
    gr1_ch2_d = gr1_ch2_q;
    gr2_ch1_d = gr2_ch1_q;
    gr2_ch2_d = gr2_ch2_q;
    if (issue_p1_q) begin
      gr1_ch1_d = dout_ch1_a_q;
      gr1_ch2_d = dout_ch2_a_q;
      gr2_ch1_d = dout_ch1_b_q;
      gr2_ch2_d = dout_ch2_b_q;
    end
  end

  // Output register stage, cleared by reset like a BRAM output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      gr1_ch1_q <= '0;
      gr1_ch2_q <= '0;
      gr2_ch1_q <= '0;
      gr2_ch2_q <= '0;
    end else begin
      gr1_ch1_q <= gr1_ch1_d;
      gr1_ch2_q <= gr1_ch2_d;
      gr2_ch1_q <= gr2_ch1_d;
      gr2_ch2_q <= gr2_ch2_d;
    end
  end

  assign gr1_ch1_out = gr1_ch1_q;
  assign gr1_ch2_out = gr1_ch2_q;
  assign gr2_ch1_out = gr2_ch1_q;
  assign gr2_ch2_out = gr2_ch2_q;
  assign valid_out   = issue_p2_q;
  assign done_out    = done_p2_q;

`ifdef GRANULE_SPLITTER_ERR_EN
  logic err_q, err_d;
  logic overdrive, abort_mid_fill;

  // Sticky protocol error: overdriven input or a frame abandoned part-way through fill.
  always_comb begin
    overdrive      = in_valid && !in_ready;
    abort_mid_fill = (state_q == FILL) && (wr_cnt_q != '0) && (wr_cnt_q < DEPTH_C);
    err_d          = err_q | overdrive;
    if (new_frame_start) begin
      err_d = overdrive | abort_mid_fill;
    end
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_granule_splitter.sv
// tb_granule_splitter: randomized frames against a queue-based reference model;
// a negedge monitor pops expected beats and compares every cycle.
module tb_granule_splitter;

  localparam int W  = 32;
  localparam int GL = 576;
  localparam int FL = 2 * GL;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                nfs = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] ch1_in = '0;
  logic signed [W-1:0] ch2_in = '0;
  logic                in_ready;
  logic signed [W-1:0] gr1_ch1_out, gr1_ch2_out, gr2_ch1_out, gr2_ch2_out;
  logic                valid_out, done_out;
`ifdef GRANULE_SPLITTER_ERR_EN
  logic                err_out;
`endif

  granule_splitter #(.WIDTH(W), .GR_LEN(GL)) dut (
    .clk             (clk),
    .rst             (rst),
    .new_frame_start (nfs),
    .ch1_in          (ch1_in),
    .ch2_in          (ch2_in),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .gr1_ch1_out     (gr1_ch1_out),
    .gr1_ch2_out     (gr1_ch2_out),
    .gr2_ch1_out     (gr2_ch1_out),
    .gr2_ch2_out     (gr2_ch2_out),
    .valid_out       (valid_out),
`ifdef GRANULE_SPLITTER_ERR_EN
    .err_out         (err_out),
`endif
    .done_out        (done_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [W-1:0] g1c1, g1c2, g2c1, g2c2;
    logic                done;
    int                  cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t last_exp;
  beat_t mon_e;
  logic  mon_exp_v;
  bit    mon_en = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    beats_seen = 0;
  int    dones_seen = 0;

  bit                  model_fill = 1'b1;
  int                  model_cnt = 0;
  logic signed [W-1:0] ref_ch1 [FL];
  logic signed [W-1:0] ref_ch2 [FL];

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a beat is due exactly when the head of the queue names this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) mon_e = exp_q.pop_front();
      mon_exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      checkOutput("valid_out", {31'b0, valid_out}, {31'b0, mon_exp_v});
      checkOutput("done_out", {31'b0, done_out}, {31'b0, mon_exp_v ? exp_q[0].done : 1'b0});
      if (mon_exp_v) begin
        mon_e = exp_q.pop_front();
        checkOutput("gr1_ch1_out", gr1_ch1_out, mon_e.g1c1);
        checkOutput("gr1_ch2_out", gr1_ch2_out, mon_e.g1c2);
        checkOutput("gr2_ch1_out", gr2_ch1_out, mon_e.g2c1);
        checkOutput("gr2_ch2_out", gr2_ch2_out, mon_e.g2c2);
        beats_seen++;
        last_exp = mon_e;
      end
      if (done_out === 1'b1) dones_seen++;
    end
  end

  // One input cycle; called and returning at posedge+1. Model updates on the accepting edge.
  task automatic applyStimulus(input logic v, input logic signed [W-1:0] a,
                               input logic signed [W-1:0] b, input logic f);
    int   n;
    logic exp_ready;
    in_valid = v;
    ch1_in   = a;
    ch2_in   = b;
    nfs      = f;
    @(negedge clk);
    n         = cyc;
    exp_ready = model_fill && (model_cnt < FL);
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    @(posedge clk);
    if (f) begin
      model_cnt  = 0;
      model_fill = 1'b1;
      exp_q.delete();
    end else if (v && exp_ready) begin
      ref_ch1[model_cnt] = a;
      ref_ch2[model_cnt] = b;
      model_cnt++;
      if (model_cnt == FL) begin
        model_fill = 1'b0;
        // Accept edge, one idle cycle, DRAIN entry, then two cycles of read latency.
        for (int k = 0; k < GL; k++) begin
          beat_t e;
          e.g1c1 = ref_ch1[k];
          e.g1c2 = ref_ch2[k];
          e.g2c1 = ref_ch1[k + GL];
          e.g2c2 = ref_ch2[k + GL];
          e.done = (k == GL - 1);
          e.cyc  = n + 4 + k;
          exp_q.push_back(e);
        end
      end
    end
    #1;
    in_valid = 1'b0;
    nfs      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  task automatic doReset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    nfs      = 1'b0;
    repeat (n) @(posedge clk);
    model_cnt  = 0;
    model_fill = 1'b1;
    exp_q.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic checkResetState();
    @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_valid_out", {31'b0, valid_out}, 32'd0);
    checkOutput("rst_done_out", {31'b0, done_out}, 32'd0);
    checkOutput("rst_gr1_ch1", gr1_ch1_out, '0);
    checkOutput("rst_gr1_ch2", gr1_ch2_out, '0);
    checkOutput("rst_gr2_ch1", gr2_ch1_out, '0);
    checkOutput("rst_gr2_ch2", gr2_ch2_out, '0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkErr(input logic exp);
`ifdef GRANULE_SPLITTER_ERR_EN
    @(negedge clk);
    checkOutput("err_out", {31'b0, err_out}, {31'b0, exp});
    @(posedge clk);
    #1;
`else
    if (exp === 1'bx) idle(1);
`endif
  endtask

  task automatic sendRamp(input int extra);
    for (int i = 0; i < FL + extra; i++) applyStimulus(1'b1, W'(i), -W'(i), 1'b0);
  endtask

  task automatic sendGapped();
    int j = 0;
    while (model_cnt < FL && model_fill && j < 5000) begin
      if (j % 2 == 0) applyStimulus(1'b1, W'(model_cnt), -W'(model_cnt), 1'b0);
      else            applyStimulus(1'b0, W'($urandom), W'($urandom), 1'b0);
      j++;
    end
  endtask

  task automatic sendRandom(input int n_accept, input int pct);
    int j = 0;
    while (model_cnt < n_accept && model_fill && j < 20000) begin
      applyStimulus($urandom_range(99) < pct, W'($urandom), W'($urandom), 1'b0);
      j++;
    end
  endtask

  task automatic waitDrain();
    int g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      idle(1);
      g++;
    end
    checkOutput("drain_complete_left", W'(exp_q.size()), '0);
    idle(5);
  endtask

  task automatic checkHold();
    @(negedge clk);
    checkOutput("hold_gr1_ch1", gr1_ch1_out, last_exp.g1c1);
    checkOutput("hold_gr1_ch2", gr1_ch2_out, last_exp.g1c2);
    checkOutput("hold_gr2_ch1", gr2_ch1_out, last_exp.g2c1);
    checkOutput("hold_gr2_ch2", gr2_ch2_out, last_exp.g2c2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    int target;
    int g;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    checkResetState();
    checkErr(1'b0);

    $display("[TB] ramp frame with over-drive");
    sendRamp(40);
    checkErr(1'b1);
    waitDrain();
    checkHold();
    checkOutput("ramp_done_count", W'(dones_seen), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkErr(1'b0);

    $display("[TB] gapped frame");
    sendGapped();
    waitDrain();
    checkHold();
    applyStimulus(1'b0, '0, '0, 1'b1);

    $display("[TB] abort at 300 samples");
    sendRandom(300, 70);
    applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b1);
    checkErr(1'b1);
    idle(3);
    sendRandom(FL, 60);
    waitDrain();
    checkHold();
    checkErr(1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkErr(1'b0);

    $display("[TB] reset mid-drain");
    d0 = dones_seen;
    sendRandom(FL, 80);
    target = beats_seen + 101;
    g = 0;
    while (beats_seen < target && g < 3000) begin
      idle(1);
      g++;
    end
    checkOutput("reached_beat_100", {31'b0, beats_seen >= target}, 32'd1);
    doReset(1);
    checkResetState();
    idle(700);
    checkOutput("no_done_after_reset", W'(dones_seen), W'(d0));

    $display("[TB] random frame after reset");
    sendRandom(FL, 50);
    waitDrain();
    checkHold();

    checkOutput("queue_empty_end", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
